// File: rtl/dual_issue_regfile_pkg.sv
// Shared types and defaults for the dual-issue integer register file.
package dual_issue_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_WR_DEF   = 2;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/dual_issue_regfile_read_port.sv
// One read port: stored-value lookup, priority bypass over the writeback slots,
// and the scoreboard lookup that feeds the issue stage's hazard check.
module regfile_read_port
  import dual_issue_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       i_rst_n,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic [NUM_REGS*DATA_W-1:0] i_regs,
  input  logic [NUM_REGS-1:0]        i_busy,
  input  logic [NUM_WR-1:0]          i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   i_wr_data,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_busy
);

  logic w_hit;

  always_comb begin
    o_data = i_regs[i_addr*DATA_W +: DATA_W];
    o_busy = i_busy[i_addr];
    w_hit  = 1'b0;
    if (BYPASS != 0) begin
      // Ascending scan so the youngest matching slot overrides older ones.
      for (int k = 0; k < NUM_WR; k++) begin
        if (i_wr_en[k] && (i_wr_addr[k*ADDR_W +: ADDR_W] == i_addr)) begin
          o_data = i_wr_data[k*DATA_W +: DATA_W];
          w_hit  = 1'b1;
        end
      end
    end
    if (w_hit) o_busy = 1'b0;
    if (!i_rst_n || (i_addr == ADDR_W'(ZERO_REG))) begin
      o_data = '0;
      o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/dual_issue_regfile.sv
// Multi-port register file with clocked writeback, optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection.
module dual_issue_regfile
  import dual_issue_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_RD   = 4,
  parameter  int NUM_WR   = NUM_WR_DEF,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic [NUM_WR-1:0]        i_iss_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_iss_addr,
  output logic [NUM_REGS-1:0]      o_busy_vec
);

  logic [DATA_W-1:0]          r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]        r_busy;
  logic [NUM_REGS*DATA_W-1:0] w_regs_flat;
  logic [NUM_REGS-1:0]        w_set;
  logic [NUM_REGS-1:0]        w_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else begin
      // Later slots are scheduled last, so the youngest writer wins a collision.
      for (int k = 0; k < NUM_WR; k++) begin
        if (i_wr_en[k] && (i_wr_addr[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)))
          r_regs[i_wr_addr[k*ADDR_W +: ADDR_W]] <= i_wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (i_iss_en[k]) w_set[i_iss_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
      if (i_wr_en[k])  w_clr[i_wr_addr[k*ADDR_W +: ADDR_W]]  = 1'b1;
    end
    w_set[0] = 1'b0;
  end

  // A new producer issued alongside the old one's writeback keeps the bit set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_busy <= '0;
    else          r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign o_busy_vec = r_busy;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
    assign w_regs_flat[r*DATA_W +: DATA_W] = r_regs[r];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR),
      .BYPASS   (BYPASS),
      .ADDR_W   (ADDR_W)
    ) u_rd (
      .i_rst_n   (i_rst_n),
      .i_addr    (i_rd_addr[i*ADDR_W +: ADDR_W]),
      .i_regs    (w_regs_flat),
      .i_busy    (r_busy),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .o_data    (o_rd_data[i*DATA_W +: DATA_W]),
      .o_busy    (o_rd_busy[i])
    );
  end

endmodule

// File: tb/tb_dual_issue_regfile.sv
// Bench for dual_issue_regfile: bypass and no-bypass instances share stimulus
// and are compared against an architectural register/scoreboard model.
module tb_dual_issue_regfile;
  import dual_issue_pkg::*;

  localparam int DW = 32, NR = 32, AW = 5, NRD = 4, NWR = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NWR-1:0]    wr_en, iss_en;
  logic [NWR*AW-1:0] wr_addr, iss_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NRD*DW-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]    rd_busy_b, rd_busy_n;
  logic [NR-1:0]     busy_vec_b, busy_vec_n;

  word_t m_regs [NR];
  bit    m_busy [NR];
  int    n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  dual_issue_regfile #(.BYPASS(1)) u_dut_byp (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
    .o_rd_busy(rd_busy_b), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_busy_vec(busy_vec_b));

  dual_issue_regfile #(.BYPASS(0)) u_dut_nobyp (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n),
    .o_rd_busy(rd_busy_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_busy_vec(busy_vec_n));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit wr_hits(int a);
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic word_t exp_data(int p, bit byp);
    int    a = int'(rd_addr[p*AW +: AW]);
    word_t d;
    if (!rst_n || a == 0) return '0;
    d = m_regs[a];
    if (byp)
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) d = wr_data[k*DW +: DW];
    return d;
  endfunction

  function automatic bit exp_busy(int p, bit byp);
    int a = int'(rd_addr[p*AW +: AW]);
    if (!rst_n || a == 0) return 1'b0;
    if (byp && wr_hits(a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [NR-1:0] exp_vec();
    logic [NR-1:0] v = '0;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
  endtask

  task automatic model_edge();
    bit issued, written;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && wr_addr[k*AW +: AW] != 0) m_regs[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
    for (int r = 1; r < NR; r++) begin
      issued = 1'b0;
      for (int k = 0; k < NWR; k++) if (iss_en[k] && int'(iss_addr[k*AW +: AW]) == r) issued = 1'b1;
      written = wr_hits(r);
      if (issued)       m_busy[r] = 1'b1;
      else if (written) m_busy[r] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [NRD-1:0] eb_b, eb_n;
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("rd_data%0d_byp", p),   rd_data_b[p*DW +: DW], exp_data(p, 1'b1));
      chk($sformatf("rd_data%0d_nobyp", p), rd_data_n[p*DW +: DW], exp_data(p, 1'b0));
      eb_b[p] = exp_busy(p, 1'b1);
      eb_n[p] = exp_busy(p, 1'b0);
    end
    chk("rd_busy_byp", rd_busy_b, eb_b);
    chk("rd_busy_nobyp", rd_busy_n, eb_n);
    chk("busy_vec_byp", busy_vec_b, exp_vec());
    chk("busy_vec_nobyp", busy_vec_n, exp_vec());
  endtask

  // Called #1 after inputs were driven at a negedge; ends at the next negedge.
  task automatic cycle();
    check_outputs();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = '0; iss_addr = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int k, input int a, input word_t d);
    wr_en[k] = 1'b1; wr_addr[k*AW +: AW] = AW'(a); wr_data[k*DW +: DW] = d;
  endtask

  task automatic set_iss(input int k, input int a);
    iss_en[k] = 1'b1; iss_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, int'($urandom_range(0, 15)));
      for (int k = 0; k < NWR; k++) begin
        wr_en[k] = ($urandom_range(0, 2) != 0);
        wr_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
        wr_data[k*DW +: DW] = $urandom;
        iss_en[k] = ($urandom_range(0, 2) == 0);
        iss_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
      end
      #1;
      cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    set_rd(0, 5);
    set_wr(0, 5, 32'h77);
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    set_wr(0, 5, 32'hDEADBEEF);
    #1; cycle();
    idle(); set_rd(0, 5);
    #1;
    chk("r5_readback", rd_data_b[0 +: DW], 32'hDEADBEEF);
    chk("r5_not_busy", rd_busy_b[0], 1'b0);
    cycle();

    idle(); set_wr(0, 10, 32'h11111111); set_wr(1, 10, 32'hCAFEBABE); set_rd(2, 10);
    #1;
    chk("ww_bypass_same_cycle", rd_data_b[2*DW +: DW], 32'hCAFEBABE);
    chk("ww_nobyp_same_cycle", rd_data_n[2*DW +: DW], 32'h0);
    cycle();
    idle(); set_rd(2, 10);
    #1;
    chk("ww_next_cycle_byp", rd_data_b[2*DW +: DW], 32'hCAFEBABE);
    chk("ww_next_cycle_nobyp", rd_data_n[2*DW +: DW], 32'hCAFEBABE);
    cycle();

    idle(); set_wr(0, 0, 32'h12345678); set_iss(1, 0); set_rd(0, 0);
    #1;
    chk("r0_same_cycle", rd_data_b[0 +: DW], 32'h0);
    cycle();
    idle(); set_rd(0, 0);
    #1;
    chk("r0_after", rd_data_b[0 +: DW], 32'h0);
    chk("r0_never_busy", busy_vec_b[0], 1'b0);
    cycle();

    idle(); set_iss(1, 7);
    #1; cycle();
    idle(); set_rd(1, 7);
    #1;
    chk("r7_busy_vec", busy_vec_b[7], 1'b1);
    chk("r7_rd_busy", rd_busy_b[1], 1'b1);
    cycle();
    idle(); set_rd(1, 7); set_wr(0, 7, 32'hA5A5A5A5);
    #1;
    chk("r7_wb_rd_busy_byp", rd_busy_b[1], 1'b0);
    chk("r7_wb_data_byp", rd_data_b[1*DW +: DW], 32'hA5A5A5A5);
    chk("r7_wb_rd_busy_nobyp", rd_busy_n[1], 1'b1);
    cycle();
    idle();
    #1;
    chk("r7_cleared", busy_vec_b[7], 1'b0);
    cycle();

    idle(); set_iss(0, 3); set_wr(1, 3, 32'h3333);
    #1; cycle();
    idle(); set_rd(0, 3);
    #1;
    chk("r3_set_beats_clear", busy_vec_b[3], 1'b1);
    chk("r3_data", rd_data_b[0 +: DW], 32'h3333);
    cycle();

    idle();
    random_cycles(300);

    idle(); set_iss(0, 9); set_wr(1, 9, 32'h55);
    #1; cycle();
    idle(); set_rd(0, 9);
    #1;
    chk("r9_busy_pre_reset", busy_vec_b[9], 1'b1);
    chk("r9_data_pre_reset", rd_data_b[0 +: DW], 32'h55);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_data", rd_data_b[0 +: DW], 32'h0);
    chk("async_rst_busy_vec", busy_vec_b, '0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    set_rd(0, 9);
    #1;
    chk("r9_after_reset", rd_data_b[0 +: DW], 32'h0);
    cycle();

    idle();
    random_cycles(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
